// File: rtl/layer_motion_updater.sv
// ---------------------------------------------------------------------------
// layer_motion_updater
//
// Per-frame write-back engine for the layer header registers. On every
// frameStart pulse it walks each layer through the shared controller port of
// the layer header block. Populated layers get their X/Y position advanced by
// the integer part of their signed fixed-point velocity. Animated sprites also
// get their current frame number stepped. The host shares the port through
// busReq/busGrant. Nothing advances while the grant is withheld.
//
// Optional build macro: LAYER_ANIM_DIVIDER_EN
//   When defined, parameter ANIM_DIV is added. Animation then only advances on
//   every ANIM_DIV-th pass, starting with the first pass after reset. When it is
//   not defined, animation advances on every pass.
//
// Ports
//   clk                 master clock
//   reset               synchronous, active-high; clears all state
//   frameStart          1-cycle pulse at start of a video frame
//   busGrant            1 = updater owns the controller port this cycle
//   ctrlReadData[15:0]  header read data (combinational on address)
//   busReq              high while a pass is in progress
//   ctrlReadWriteLayer  layer being accessed
//   layerRegisterIndex  header register being accessed
//   writeLayerData      data to write
//   writeLayerEn        write strobe, one cycle per write
//   busy                pass in progress (same as busReq)
//   done                1-cycle pulse when a pass completes
// ---------------------------------------------------------------------------
module layer_motion_updater #(
  parameter int NUM_LAYERS    = 32,
  parameter int VEL_FRAC_BITS = 4
`ifdef LAYER_ANIM_DIVIDER_EN
  , parameter int ANIM_DIV    = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic        busGrant,
  input  logic [15:0] ctrlReadData,
  output logic        busReq,
  output logic [4:0]  ctrlReadWriteLayer,
  output logic [2:0]  layerRegisterIndex,
  output logic [15:0] writeLayerData,
  output logic        writeLayerEn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, RD_FLAGS, RD_VX, RD_X, WR_X, RD_VY, RD_Y, WR_Y, RD_FRM, WR_FRM, NEXT
  } stateType;

  stateType state, nextState;

  logic [4:0]  layer;
  logic        pending;
  logic        animCandidate;
  logic [15:0] delta;
  logic [15:0] dataReg;
  logic        doneReg;

  logic signed [15:0] readDelta;
  logic               lastLayer;
  logic               animSlot;
  logic               animate;
  logic [8:0]         curPlusOne;
  logic [7:0]         nxtFrame;

`ifdef LAYER_ANIM_DIVIDER_EN
  logic [7:0] animCount;
  assign animSlot = (animCount == 8'd0);
`else
  assign animSlot = 1'b1;
`endif

  // Integer pixel step: arithmetic shift, so small negative velocities floor to -1
  assign readDelta  = $signed(ctrlReadData) >>> VEL_FRAC_BITS;
  assign lastLayer  = (layer == 5'(NUM_LAYERS - 1));
  assign animate    = animCandidate & animSlot;

  // Frame step uses 9 bits so cur=255 wraps to 0 rather than overflowing
  assign curPlusOne = {1'b0, dataReg[15:8]} + 9'd1;
  assign nxtFrame   = ((dataReg[7:0] == 8'd0) || (curPlusOne >= {1'b0, dataReg[7:0]}))
                      ? 8'd0 : curPlusOne[7:0];

  assign busReq             = (state != IDLE);
  assign busy               = busReq;
  assign done               = doneReg;
  assign ctrlReadWriteLayer = layer;

  // Next-state and per-state port drive. A withheld grant freezes the state
  // and suppresses the write strobe. The address stays put because it only
  // depends on the state.
  always_comb begin
    nextState          = state;
    layerRegisterIndex = 3'd0;
    writeLayerData     = 16'd0;
    writeLayerEn       = 1'b0;
    case (state)
      IDLE: begin
        if (frameStart || pending) nextState = RD_FLAGS;
      end
      RD_FLAGS: begin
        layerRegisterIndex = 3'd0;
        if (busGrant) nextState = ctrlReadData[0] ? RD_VX : NEXT;
      end
      RD_VX: begin
        layerRegisterIndex = 3'd5;
        if (busGrant) nextState = (readDelta == 16'sd0) ? RD_VY : RD_X;
      end
      RD_X: begin
        layerRegisterIndex = 3'd3;
        if (busGrant) nextState = WR_X;
      end
      WR_X: begin
        layerRegisterIndex = 3'd3;
        writeLayerData     = dataReg + delta;
        writeLayerEn       = busGrant;
        if (busGrant) nextState = RD_VY;
      end
      RD_VY: begin
        layerRegisterIndex = 3'd6;
        if (busGrant) begin
          if (readDelta != 16'sd0) nextState = RD_Y;
          else                     nextState = animate ? RD_FRM : NEXT;
        end
      end
      RD_Y: begin
        layerRegisterIndex = 3'd4;
        if (busGrant) nextState = WR_Y;
      end
      WR_Y: begin
        layerRegisterIndex = 3'd4;
        writeLayerData     = dataReg + delta;
        writeLayerEn       = busGrant;
        if (busGrant) nextState = animate ? RD_FRM : NEXT;
      end
      RD_FRM: begin
        layerRegisterIndex = 3'd7;
        if (busGrant) nextState = WR_FRM;
      end
      WR_FRM: begin
        layerRegisterIndex = 3'd7;
        writeLayerData     = {nxtFrame, dataReg[7:0]};
        writeLayerEn       = busGrant;
        if (busGrant) nextState = NEXT;
      end
      NEXT: begin
        if (busGrant) nextState = lastLayer ? IDLE : RD_FLAGS;
      end
      default: nextState = IDLE;
    endcase
  end

  // State register, layer walk, captured header fields and the pending frame
  // request. A frameStart seen mid-pass queues a single restart. A frameStart
  // seen in IDLE, including the done cycle, starts the pass directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      layer         <= 5'd0;
      pending       <= 1'b0;
      animCandidate <= 1'b0;
      delta         <= 16'd0;
      dataReg       <= 16'd0;
      doneReg       <= 1'b0;
    end else begin
      state   <= nextState;
      doneReg <= (state == NEXT) && busGrant && lastLayer;

      if (state == IDLE)   pending <= 1'b0;
      else if (frameStart) pending <= 1'b1;

      if (busGrant) begin
        case (state)
          RD_FLAGS:           animCandidate <= ctrlReadData[1] & ctrlReadData[3];
          RD_VX, RD_VY:       delta         <= readDelta;
          RD_X, RD_Y, RD_FRM: dataReg       <= ctrlReadData;
          NEXT:               layer         <= lastLayer ? 5'd0 : layer + 5'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef LAYER_ANIM_DIVIDER_EN
  // Pass counter for the animation divider. It advances on each completed
  // pass, so the pass that sees zero is the one that animates.
  always_ff @(posedge clk) begin
    if (reset) begin
      animCount <= 8'd0;
    end else if ((state == NEXT) && busGrant && lastLayer) begin
      animCount <= (animCount >= 8'(ANIM_DIV - 1)) ? 8'd0 : animCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_motion_updater.sv
// ---------------------------------------------------------------------------
// tb_layer_motion_updater
//
// Directed bench for layer_motion_updater. A behavioural model of the layer
// header memory answers the controller port. Writes seen on the strobe are
// logged and applied back into that memory so multi-pass sequences evolve.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_layer_motion_updater;

  logic        clk = 1'b0;
  logic        reset;
  logic        frameStart;
  logic        busGrant;
  logic [15:0] ctrlReadData;
  logic        busReq;
  logic [4:0]  ctrlReadWriteLayer;
  logic [2:0]  layerRegisterIndex;
  logic [15:0] writeLayerData;
  logic        writeLayerEn;
  logic        busy;
  logic        done;

  typedef struct {
    logic [4:0]  layer;
    logic [2:0]  index;
    logic [15:0] data;
  } writeRec;

  logic [15:0] mem [0:31][0:7];
  writeRec     writes[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          busyTicks  = 0;
  int          doneTicks  = 0;

`ifdef LAYER_ANIM_DIVIDER_EN
  localparam bit DIV_BUILD = 1'b1;
`else
  localparam bit DIV_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  assign ctrlReadData = mem[ctrlReadWriteLayer][layerRegisterIndex];

  layer_motion_updater dut (
    .clk                (clk),
    .reset              (reset),
    .frameStart         (frameStart),
    .busGrant           (busGrant),
    .ctrlReadData       (ctrlReadData),
    .busReq             (busReq),
    .ctrlReadWriteLayer (ctrlReadWriteLayer),
    .layerRegisterIndex (layerRegisterIndex),
    .writeLayerData     (writeLayerData),
    .writeLayerEn       (writeLayerEn),
    .busy               (busy),
    .done               (done)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
  endtask

  // Advance to the next falling edge, then sample outputs and apply any write
  task automatic tick();
    @(negedge clk);
    if (busy) busyTicks++;
    if (done) doneTicks++;
    if (!reset && writeLayerEn) begin
      writes.push_back('{layer: ctrlReadWriteLayer, index: layerRegisterIndex, data: writeLayerData});
      mem[ctrlReadWriteLayer][layerRegisterIndex] = writeLayerData;
    end
  endtask

  task automatic clearMem();
    for (int l = 0; l < 32; l++)
      for (int r = 0; r < 8; r++)
        mem[l][r] = 16'd0;
  endtask

  // Load one layer header: flags, X, Y, VX, VY, frames
  task automatic applyStimulus(input int l, input logic [15:0] flags, input logic [15:0] x,
                               input logic [15:0] vx, input logic [15:0] y,
                               input logic [15:0] vy, input logic [15:0] frames);
    mem[l][0] = flags;
    mem[l][3] = x;
    mem[l][4] = y;
    mem[l][5] = vx;
    mem[l][6] = vy;
    mem[l][7] = frames;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulseFrame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  // One full pass: clears the counters and write log, then waits (bounded) for done
  task automatic runPass(input string tag);
    busyTicks = 0;
    doneTicks = 0;
    writes.delete();
    pulseFrame();
    for (int c = 0; c < 2000 && doneTicks == 0; c++) tick();
    checkOutput({tag, "_passDone"}, doneTicks, 1);
  endtask

  int strobesLow;
  logic [2:0] heldIndex;

  initial begin
    reset      = 1'b1;
    frameStart = 1'b0;
    busGrant   = 1'b1;
    clearMem();
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_busy",   busy, 0);
    checkOutput("rst_busReq", busReq, 0);
    checkOutput("rst_done",   done, 0);
    checkOutput("rst_wrEn",   writeLayerEn, 0);
    checkOutput("rst_layer",  ctrlReadWriteLayer, 0);
    checkOutput("rst_index",  layerRegisterIndex, 0);
    checkOutput("rst_data",   writeLayerData, 0);

    $display("[TB] empty pass");
    runPass("empty");
    repeat (5) tick();
    checkOutput("empty_busyCycles", busyTicks, 64);
    checkOutput("empty_doneOnce",   doneTicks, 1);
    checkOutput("empty_writes",     writes.size(), 0);

    $display("[TB] sprite move on layer 3");
    clearMem();
    applyStimulus(3, 16'h0003, 16'd100, 16'h0030, 16'd50, 16'hFFE0, 16'h0000);
    runPass("move");
    checkOutput("move_busyCycles", busyTicks, 70);
    checkOutput("move_writes", writes.size(), 2);
    if (writes.size() == 2) begin
      checkOutput("move_xLayer", writes[0].layer, 3);
      checkOutput("move_xIndex", writes[0].index, 3);
      checkOutput("move_xData",  writes[0].data, 103);
      checkOutput("move_yLayer", writes[1].layer, 3);
      checkOutput("move_yIndex", writes[1].index, 4);
      checkOutput("move_yData",  writes[1].data, 48);
    end

    $display("[TB] hidden layer still moves");
    clearMem();
    applyStimulus(7, 16'h0005, 16'd1, 16'h0020, 16'd0, 16'h0000, 16'h0000);
    runPass("hidden");
    checkOutput("hidden_writes", writes.size(), 1);
    checkOutput("hidden_x", mem[7][3], 3);

    $display("[TB] position wrap and sub-pixel velocity");
    clearMem();
    applyStimulus(0, 16'h0001, 16'h7FFF, 16'h0010, 16'd0, 16'h0000, 16'h0000);
    runPass("wrap");
    checkOutput("wrap_writes", writes.size(), 1);
    checkOutput("wrap_x", mem[0][3], 16'h8000);
    applyStimulus(0, 16'h0001, 16'h7FFF, 16'h000F, 16'd0, 16'h0000, 16'h0000);
    runPass("subpix");
    checkOutput("subpix_writes", writes.size(), 0);
    checkOutput("subpix_x", mem[0][3], 16'h7FFF);
    applyStimulus(0, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFF0, 16'h0000);
    runPass("negfloor");
    checkOutput("negfloor_writes", writes.size(), 2);
    checkOutput("negfloor_x", mem[0][3], 16'hFFFF);
    checkOutput("negfloor_y", mem[0][4], 16'hFFFF);

    $display("[TB] animation frame stepping");
    clearMem();
    doReset();
    applyStimulus(5, 16'h000B, 16'd0, 16'h0000, 16'd0, 16'h0000, 16'h0304);
    runPass("animLast");
    checkOutput("animLast_busyCycles", busyTicks, 68);
    checkOutput("animLast_writes", writes.size(), 1);
    if (writes.size() == 1) begin
      checkOutput("animLast_layer", writes[0].layer, 5);
      checkOutput("animLast_index", writes[0].index, 7);
      checkOutput("animLast_data",  writes[0].data, 16'h0004);
    end
    doReset();
    mem[5][7] = 16'h0104;
    runPass("animStep");
    checkOutput("animStep_frm", mem[5][7], 16'h0204);
    doReset();
    mem[5][7] = 16'h0300;
    runPass("animZero");
    checkOutput("animZero_writes", writes.size(), 1);
    checkOutput("animZero_frm", mem[5][7], 16'h0000);
    clearMem();
    doReset();
    applyStimulus(6, 16'h0009, 16'd0, 16'h0000, 16'd0, 16'h0000, 16'h0304);
    runPass("text");
    checkOutput("text_writes", writes.size(), 0);

    $display("[TB] grant withheld during X write");
    clearMem();
    applyStimulus(0, 16'h0001, 16'd10, 16'h0010, 16'd0, 16'h0000, 16'h0000);
    busyTicks = 0;
    doneTicks = 0;
    writes.delete();
    pulseFrame();
    for (int c = 0; c < 50 && !(busy && layerRegisterIndex == 3'd3); c++) tick();
    @(posedge clk);
    #1 busGrant = 1'b0;
    strobesLow = 0;
    repeat (5) begin
      tick();
      if (writeLayerEn) strobesLow++;
    end
    heldIndex = layerRegisterIndex;
    @(posedge clk);
    #1 busGrant = 1'b1;
    for (int c = 0; c < 2000 && doneTicks == 0; c++) tick();
    checkOutput("grant_noStrobeLow", strobesLow, 0);
    checkOutput("grant_heldIndex", heldIndex, 3);
    checkOutput("grant_passDone", doneTicks, 1);
    checkOutput("grant_writes", writes.size(), 1);
    checkOutput("grant_x", mem[0][3], 11);

    $display("[TB] frameStart during a pass");
    clearMem();
    busyTicks = 0;
    doneTicks = 0;
    pulseFrame();
    repeat (10) tick();
    pulseFrame();
    repeat (5) tick();
    pulseFrame();
    for (int c = 0; c < 400 && doneTicks < 2; c++) begin
      tick();
      if (done && doneTicks == 1) begin
        tick();
        checkOutput("pending_restart", busy, 1);
      end
    end
    repeat (100) tick();
    checkOutput("pending_dones", doneTicks, 2);
    checkOutput("pending_busyCycles", busyTicks, 128);

    $display("[TB] reset mid-pass");
    clearMem();
    applyStimulus(0, 16'h0001, 16'd0, 16'h0010, 16'd0, 16'h0000, 16'h0000);
    busyTicks = 0;
    doneTicks = 0;
    writes.delete();
    pulseFrame();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy",  busy, 0);
    checkOutput("midrst_busReq", busReq, 0);
    checkOutput("midrst_wrEn",  writeLayerEn, 0);
    checkOutput("midrst_index", layerRegisterIndex, 0);
    checkOutput("midrst_layer", ctrlReadWriteLayer, 0);
    reset = 1'b0;
    repeat (20) tick();
    checkOutput("midrst_writes", writes.size(), 0);
    checkOutput("midrst_dones", doneTicks, 0);

    $display("[TB] animation over eight passes");
    clearMem();
    doReset();
    applyStimulus(2, 16'h000B, 16'd0, 16'h0000, 16'd0, 16'h0000, 16'h0008);
    for (int p = 1; p <= 8; p++) begin
      runPass($sformatf("div%0d", p));
      checkOutput($sformatf("div%0d_frameWrites", p), writes.size(),
                  DIV_BUILD ? ((p == 1 || p == 5) ? 1 : 0) : 1);
    end
    checkOutput("div_finalFrm", mem[2][7], DIV_BUILD ? 16'h0208 : 16'h0008);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
